// File: rtl/updown_mod_counter.sv
// updown_mod_counter
//   Parametrised up/down modulo counter with synchronous clear, parallel
//   load, wrap/saturate mode and a registered one-cycle limit flag.
//   Successor of the 3-bit T-flip-flop up-counter: with WIDTH=3, MODULO=8,
//   wrap mode and only count_up driven it produces the same sequence.
//
//   Optional build macro: COUNTER_PRESCALE_EN
//     When defined, qualified step requests pass through a PRESCALE:1
//     divider, so the counter moves once per PRESCALE requests.
//
// Parameters
//   WIDTH    counter width, 1..32
//   MODULO   count range 0..MODULO-1, 2..2**WIDTH
//   PRESCALE request divider ratio (prescale build only), 2..256
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   clear      synchronous clear (highest priority)
//   load       synchronous parallel load of load_val (clamped to MODULO-1)
//   load_val   load value
//   count_up   increment request
//   count_down decrement request (both requests together = hold)
//   sat_mode   0 = wrap at limits, 1 = saturate at limits
//   count      registered count
//   limit      registered flag: previous step wrapped or was blocked
//   at_max     count == MODULO-1 (combinational)
//   at_zero    count == 0 (combinational)
module updown_mod_counter #(
  parameter int              WIDTH    = 3,
  parameter longint unsigned MODULO   = 8,
  parameter int              PRESCALE = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             count_up,
  input  logic             count_down,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] count,
  output logic             limit,
  output logic             at_max,
  output logic             at_zero
);

  // Terminal value held one bit wider so MODULO = 2**WIDTH compares cleanly.
  localparam longint unsigned MAX_L = MODULO - 1;
  localparam logic [WIDTH:0]   MAX_V = MAX_L[WIDTH:0];
  localparam logic [WIDTH-1:0] MAX_W = MAX_L[WIDTH-1:0];

  logic [WIDTH:0]   cnt_x, ld_x;
  logic [WIDTH-1:0] nxt_cnt;
  logic             nxt_lim;
  logic             step_up, step_dn, step_req, step_fire;

  assign cnt_x    = {1'b0, count};
  assign ld_x     = {1'b0, load_val};
  assign step_up  = count_up & ~count_down;
  assign step_dn  = count_down & ~count_up;
  assign step_req = step_up | step_dn;

  assign at_max  = (cnt_x == MAX_V);
  assign at_zero = (count == '0);

`ifdef COUNTER_PRESCALE_EN
  localparam int            PS_W   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_TOP = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_q, ps_d;

  // Only qualified requests advance the divider; direction is irrelevant.
  assign step_fire = step_req && (ps_q == PS_TOP);

  always_comb begin
    ps_d = ps_q;
    if (clear || load)  ps_d = '0;
    else if (step_fire) ps_d = '0;
    else if (step_req)  ps_d = ps_q + PS_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ps_q <= '0;
    else         ps_q <= ps_d;
  end
`else
  assign step_fire = step_req;
`endif

  always_comb begin
    nxt_cnt = count;
    nxt_lim = 1'b0;
    if (clear) begin
      nxt_cnt = '0;
    end else if (load) begin
      nxt_cnt = (ld_x > MAX_V) ? MAX_W : load_val;
    end else if (step_fire && step_up) begin
      if (cnt_x < MAX_V) begin
        nxt_cnt = count + WIDTH'(1);
      end else begin
        nxt_lim = 1'b1;
        nxt_cnt = sat_mode ? count : '0;
      end
    end else if (step_fire && step_dn) begin
      if (count != '0) begin
        nxt_cnt = count - WIDTH'(1);
      end else begin
        nxt_lim = 1'b1;
        nxt_cnt = sat_mode ? count : MAX_W;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
      limit <= 1'b0;
    end else begin
      count <= nxt_cnt;
      limit <= nxt_lim;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: two instances (MODULO=8 and MODULO=6)
// share one stimulus stream. Each driven cycle queues the expected
// post-edge state of both; a monitor pops and compares after every edge.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       clear = 1'b0, load = 1'b0, count_up = 1'b0, count_down = 1'b0, sat_mode = 1'b0;
  logic [2:0] load_val = 3'd0;
  logic [2:0] c8, c6;
  logic       l8, l6, am8, am6, az8, az6;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      nm;
    logic [2:0] c8;
    logic       l8;
    logic [2:0] c6;
    logic       l6;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(3), .MODULO(8), .PRESCALE(4)) u8 (
    .clk(clk), .resetn(resetn), .clear(clear), .load(load), .load_val(load_val),
    .count_up(count_up), .count_down(count_down), .sat_mode(sat_mode),
    .count(c8), .limit(l8), .at_max(am8), .at_zero(az8)
  );

  updown_mod_counter #(.WIDTH(3), .MODULO(6), .PRESCALE(4)) u6 (
    .clk(clk), .resetn(resetn), .clear(clear), .load(load), .load_val(load_val),
    .count_up(count_up), .count_down(count_down), .sat_mode(sat_mode),
    .count(c6), .limit(l6), .at_max(am6), .at_zero(az6)
  );

  task automatic cmp(input string nm, input string tag, input int modv,
                     input logic [2:0] ac, input logic al, input logic aam, input logic aaz,
                     input logic [2:0] ec, input logic el);
    logic eam, eaz;
    eam = (int'(ec) == modv - 1);
    eaz = (ec == 3'd0);
    checks++;
    if ({ac, al, aam, aaz} !== {ec, el, eam, eaz}) begin
      failures++;
      $display("FAIL %s/%s: got count=%0d limit=%b at_max=%b at_zero=%b, expected count=%0d limit=%b at_max=%b at_zero=%b",
               nm, tag, ac, al, aam, aaz, ec, el, eam, eaz);
    end
  endtask

  // Monitor: every edge, consume one expectation if one is pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp(e.nm, "m8", 8, c8, l8, am8, az8, e.c8, e.l8);
        cmp(e.nm, "m6", 6, c6, l6, am6, az6, e.c6, e.l6);
      end
    end
  end

  task automatic cyc(input string nm, input logic cl, input logic ld, input logic [2:0] lv,
                     input logic up, input logic dn, input logic sat,
                     input logic [2:0] e8, input logic el8, input logic [2:0] e6, input logic el6);
    @(negedge clk);
    clear = cl; load = ld; load_val = lv; count_up = up; count_down = dn; sat_mode = sat;
    q.push_back('{nm, e8, el8, e6, el6});
  endtask

  task automatic idle();
    clear = 1'b0; load = 1'b0; count_up = 1'b0; count_down = 1'b0; sat_mode = 1'b0;
  endtask

  task automatic now_chk(input string nm, input logic [2:0] e8, input logic el8,
                         input logic [2:0] e6, input logic el6);
    cmp(nm, "m8", 8, c8, l8, am8, az8, e8, el8);
    cmp(nm, "m6", 6, c6, l6, am6, az6, e6, el6);
  endtask

  initial begin
    #3;
    now_chk("reset", 3'd0, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

`ifdef COUNTER_PRESCALE_EN
    // Every 4th request steps; a load zeroes the divider.
    cyc("ps1",  0,0,0, 1,0,0, 3'd0,0, 3'd0,0);
    cyc("ps2",  0,0,0, 1,0,0, 3'd0,0, 3'd0,0);
    cyc("ps3",  0,0,0, 1,0,0, 3'd0,0, 3'd0,0);
    cyc("ps4",  0,0,0, 1,0,0, 3'd1,0, 3'd1,0);
    cyc("ps5",  0,0,0, 1,0,0, 3'd1,0, 3'd1,0);
    cyc("ps6",  0,0,0, 1,0,0, 3'd1,0, 3'd1,0);
    cyc("ps7",  0,0,0, 1,0,0, 3'd1,0, 3'd1,0);
    cyc("ps8",  0,0,0, 1,0,0, 3'd2,0, 3'd2,0);
    cyc("ps9",  0,0,0, 1,0,0, 3'd2,0, 3'd2,0);
    cyc("ps10", 0,0,0, 1,0,0, 3'd2,0, 3'd2,0);
    cyc("ps11", 0,0,0, 1,0,0, 3'd2,0, 3'd2,0);
    cyc("ps12", 0,0,0, 1,0,0, 3'd3,0, 3'd3,0);
    cyc("ps13", 0,0,0, 1,0,0, 3'd3,0, 3'd3,0);
    cyc("ps14", 0,0,0, 1,0,0, 3'd3,0, 3'd3,0);
    cyc("psld", 0,1,1, 1,0,0, 3'd1,0, 3'd1,0);
    cyc("psr1", 0,0,0, 1,0,0, 3'd1,0, 3'd1,0);
    cyc("psr2", 0,0,0, 1,0,0, 3'd1,0, 3'd1,0);
    cyc("psr3", 0,0,0, 1,0,0, 3'd1,0, 3'd1,0);
    cyc("psr4", 0,0,0, 1,0,0, 3'd2,0, 3'd2,0);
`else
    // Up-count with wrap: MODULO=8 wraps after 7, MODULO=6 after 5.
    cyc("up1", 0,0,0, 1,0,0, 3'd1,0, 3'd1,0);
    cyc("up2", 0,0,0, 1,0,0, 3'd2,0, 3'd2,0);
    cyc("up3", 0,0,0, 1,0,0, 3'd3,0, 3'd3,0);
    cyc("up4", 0,0,0, 1,0,0, 3'd4,0, 3'd4,0);
    cyc("up5", 0,0,0, 1,0,0, 3'd5,0, 3'd5,0);
    cyc("up6", 0,0,0, 1,0,0, 3'd6,0, 3'd0,1);
    cyc("up7", 0,0,0, 1,0,0, 3'd7,0, 3'd1,0);
    cyc("up8", 0,0,0, 1,0,0, 3'd0,1, 3'd2,0);
    cyc("up9", 0,0,0, 1,0,0, 3'd1,0, 3'd3,0);
    // Load 2, then saturating down-count.
    cyc("ld2", 0,1,2, 0,0,0, 3'd2,0, 3'd2,0);
    cyc("dn1", 0,0,0, 0,1,1, 3'd1,0, 3'd1,0);
    cyc("dn2", 0,0,0, 0,1,1, 3'd0,0, 3'd0,0);
    cyc("dn3", 0,0,0, 0,1,1, 3'd0,1, 3'd0,1);
    cyc("dn4", 0,0,0, 0,1,1, 3'd0,1, 3'd0,1);
    // Down wrap from 0, then saturate at the top.
    cyc("dnw", 0,0,0, 0,1,0, 3'd7,1, 3'd5,1);
    cyc("ups", 0,0,0, 1,0,1, 3'd7,1, 3'd5,1);
    // Load clamp (7 >= 6 for the small counter) and clear priority.
    cyc("ld7", 0,1,7, 0,0,0, 3'd7,0, 3'd5,0);
    cyc("clr", 1,1,3, 1,0,0, 3'd0,0, 3'd0,0);
    // Both requests or none: hold.
    cyc("ld3", 0,1,3, 0,0,0, 3'd3,0, 3'd3,0);
    cyc("ud1", 0,0,0, 1,1,0, 3'd3,0, 3'd3,0);
    cyc("ud2", 0,0,0, 1,1,1, 3'd3,0, 3'd3,0);
    cyc("ud3", 0,0,0, 1,1,0, 3'd3,0, 3'd3,0);
    cyc("nop", 0,0,0, 0,0,0, 3'd3,0, 3'd3,0);
    cyc("ld5", 0,1,5, 0,0,0, 3'd5,0, 3'd5,0);
    // Async reset between edges.
    @(negedge clk);
    idle();
    #2 resetn = 1'b0;
    #1 now_chk("areset", 3'd0, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    cyc("rs1", 0,0,0, 1,0,0, 3'd1,0, 3'd1,0);
    cyc("rs2", 0,0,0, 1,0,0, 3'd2,0, 3'd2,0);
`endif

    @(negedge clk);
    idle();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised successor of the team's 3-bit T-flip-flop up-counter.
- Adds the following to plain count-up:
  - configurable width and modulus
  - up/down direction
  - synchronous clear and parallel load
  - wrap or saturate mode
  - registered wrap/limit flag
- Used by ALU sequencing logic (operand/step counters) and by the display/test harness as a general event counter.

Parameters:
- WIDTH, 3, counter width in bits; legal range 1..32.
- MODULO, 8, count range 0..MODULO-1; legal range 2..2**WIDTH.
- PRESCALE, 4, enable-pulse divider ratio; used only with the optional feature; legal range 2..256.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear to 0
- load  in  1  synchronous parallel load
- load_val  in  WIDTH  value for load
- count_up  in  1  increment request
- count_down  in  1  decrement request
- sat_mode  in  1  0 = wrap at limits, 1 = saturate at limits
- count  out  WIDTH  current count (registered)
- limit  out  1  registered one-cycle flag: last step wrapped or was blocked by saturation
- at_max  out  1  combinational: count == MODULO-1
- at_zero  out  1  combinational: count == 0

Behaviour:
- Reset (resetn=0, asynchronous, any time): count=0, limit=0, prescaler=0. Operation resumes on the first rising clk edge after resetn deasserts.
- All other state changes happen on the rising edge of clk. count and limit reflect an input on the next edge (latency 1).
- Priority per edge: clear > load > step > hold.
- clear=1: count<=0, limit<=0, prescaler<=0.
- load=1 (clear=0):
  - count <= load_val if load_val < MODULO; otherwise count <= MODULO-1 (clamped).
  - limit<=0.
- Step qualification: step_up = count_up & ~count_down; step_dn = count_down & ~count_up.
- count_up=count_down=1: hold, limit<=0.
- Neither asserted: hold, limit<=0.
- step_up:
  - count < MODULO-1: count<=count+1, limit<=0.
  - count == MODULO-1, sat_mode=0: count<=0, limit<=1.
  - count == MODULO-1, sat_mode=1: count holds, limit<=1.
- step_dn:
  - count > 0: count<=count-1, limit<=0.
  - count == 0, sat_mode=0: count<=MODULO-1, limit<=1.
  - count == 0, sat_mode=1: count holds, limit<=1.
- limit is high for exactly one cycle per limit event. Consecutive blocked steps in saturate mode keep limit high every such cycle.
- sat_mode may change on any cycle and takes effect on the same edge it is sampled.
- Arithmetic is done WIDTH+1 bits wide internally. count never holds a value >= MODULO. With MODULO = 2**WIDTH the wrap is the natural overflow.
- Width-parameterisation: with WIDTH=3, MODULO=8, sat_mode=0, count_down=0, clear=0, load=0, the count sequence matches the original 3-bit up-counter driven by count_up.

Optional Feature:
- Macro: COUNTER_PRESCALE_EN.
- Defined:
  - An internal prescaler (ceil(log2 PRESCALE) bits) counts qualified step requests.
  - The counter steps only when the prescaler reaches PRESCALE-1; the prescaler then returns to 0.
  - Non-qualifying cycles (no request, or both requests asserted) leave the prescaler unchanged.
  - clear, load and reset zero the prescaler.
  - A direction change does not reset the prescaler.
- Not defined: no prescaler logic. Every qualified request steps the counter, and PRESCALE is ignored.

Test Plan:
- Reset/up-wrap: WIDTH=3, MODULO=8, sat_mode=0. Pulse resetn low, then hold count_up=1 for 9 cycles -> count 1..7,0,1; limit=1 only in the cycle count shows 0; at_max=1 when count=7.
- Down-saturate: MODULO=6, load_val=2 load, then count_down=1 with sat_mode=1 for 4 cycles -> count 1,0,0,0; limit=1 in the last two cycles; at_zero=1.
- Load clamp / priority: MODULO=6. load=1 with load_val=7 -> count=5. Then clear=1 with load=1 and count_up=1 -> count=0, limit=0.
- Simultaneous up/down: count=3, count_up=count_down=1 for 3 cycles -> count stays 3, limit=0.
- Async reset mid-count: count=5, drop resetn between edges -> count=0 immediately, before the next edge. Release resetn -> count_up resumes counting from 1.
- Prescale (COUNTER_PRESCALE_EN, PRESCALE=4): count_up=1 for 12 cycles -> count advances on every 4th cycle, reaching 3. A load mid-sequence restarts the 4-cycle spacing.
